// File: rtl/afifo_rd_packer.sv
// afifo_rd_packer
//   Read-side drain for afifo. Pops DSIZE-bit entries from the FIFO read port
//   and packs LANES of them into one wide word. Lane 0 holds the first entry
//   popped. The word is offered on a valid/ready master interface. A flush
//   pulse emits a partial word, and m_keep marks the lanes that hold data.
//
//   Optional feature: define AFIFO_PACK_TIMEOUT_EN to add an idle timeout.
//   A partial word that sees no pop for TO_CYCLES consecutive cycles is then
//   emitted exactly as if flush had been pulsed.
//
// Ports
//   rclk     in   read-domain clock, rising edge
//   rrst_n   in   synchronous active-low reset
//   rempty   in   afifo empty flag
//   rdata    in   afifo read data, valid while rempty=0
//   rinc     out  pop strobe to afifo (combinational)
//   flush    in   single-cycle request to emit the current partial word
//   m_valid  out  output word valid (registered)
//   m_ready  in   downstream accept
//   m_data   out  packed word, lane 0 in the LSBs (registered)
//   m_keep   out  per-lane data-present mask, contiguous from bit 0 (registered)
module afifo_rd_packer #(
   parameter int DSIZE     = 8,
   parameter int LANES     = 4,
   parameter int TO_CYCLES = 16
) (
   input  logic                     rclk,
   input  logic                     rrst_n,
   input  logic                     rempty,
   input  logic [DSIZE-1:0]         rdata,
   output logic                     rinc,
   input  logic                     flush,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DSIZE*LANES-1:0]   m_data,
   output logic [LANES-1:0]         m_keep
);

   localparam int CNT_W = $clog2(LANES);

   if (LANES < 2 || LANES > 16 || TO_CYCLES < 1) begin : g_bad_cfg
      $error("afifo_rd_packer: LANES must be 2..16 and TO_CYCLES at least 1");
   end

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_lane;
   logic             timeout_hit;
   logic             do_flush;

   // In HOLD the FIFO is popped only in the cycle the word is handed off.
   // The popped entry then becomes lane 0 of the next word, so no cycle is lost.
   assign rinc      = rrst_n & ~rempty & ((state == FILL) | m_ready);
   assign last_lane = (cnt == CNT_W'(LANES - 1));

`ifdef AFIFO_PACK_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TO_CYCLES + 1);

   logic [IDLE_W-1:0] idle_cnt;
   logic              idle_cyc;

   assign idle_cyc    = (state == FILL) && (cnt != '0) && !rinc;
   // The hit fires on the TO_CYCLES-th idle cycle, before the counter
   // would reach TO_CYCLES.
   assign timeout_hit = idle_cyc && (idle_cnt == IDLE_W'(TO_CYCLES - 1));

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         idle_cnt <= '0;
      end else if (idle_cyc && !timeout_hit) begin
         idle_cnt <= idle_cnt + 1'b1;
      end else begin
         idle_cnt <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // A flush with nothing captured, and no entry arriving, is dropped.
   assign do_flush = (flush | timeout_hit) & ((cnt != '0) | rinc);

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         state   <= FILL;
         cnt     <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_keep  <= '0;
      end else begin
         case (state)
            FILL: begin
               if (rinc) begin
                  m_data[cnt*DSIZE +: DSIZE] <= rdata;
                  m_keep[cnt]                <= 1'b1;
               end
               if ((rinc && last_lane) || do_flush) begin
                  state   <= HOLD;
                  m_valid <= 1'b1;
                  cnt     <= '0;
               end else if (rinc) begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (m_ready) begin
                  state   <= FILL;
                  m_valid <= 1'b0;
                  if (rinc) begin
                     m_data <= (DSIZE*LANES)'(rdata);
                     m_keep <= LANES'(1);
                     cnt    <= CNT_W'(1);
                  end else begin
                     m_data <= '0;
                     m_keep <= '0;
                     cnt    <= '0;
                  end
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_afifo_rd_packer.sv
// tb_afifo_rd_packer
//   Randomized and directed bench for afifo_rd_packer. The bench acts as the
//   afifo, using a byte queue. A transaction-level reference model tracks the
//   bytes gathered for the current word and the word being offered. The model
//   predicts rinc, m_valid, m_data and m_keep on every cycle.
module tb_afifo_rd_packer;

   localparam int DSIZE     = 8;
   localparam int LANES     = 4;
   localparam int TO_CYCLES = 16;

   logic                   rclk = 1'b0;
   logic                   rrst_n = 1'b0;
   logic                   rempty = 1'b1;
   logic [DSIZE-1:0]       rdata = '0;
   logic                   rinc;
   logic                   flush = 1'b0;
   logic                   m_valid;
   logic                   m_ready = 1'b0;
   logic [DSIZE*LANES-1:0] m_data;
   logic [LANES-1:0]       m_keep;

   afifo_rd_packer #(
      .DSIZE    (DSIZE),
      .LANES    (LANES),
      .TO_CYCLES(TO_CYCLES)
   ) dut (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .rempty (rempty),
      .rdata  (rdata),
      .rinc   (rinc),
      .flush  (flush),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data (m_data),
      .m_keep (m_keep)
   );

   always #5 rclk = ~rclk;

   // FIFO contents, and the reference model state
   logic [DSIZE-1:0]       fifo[$];
   logic [DSIZE-1:0]       cur[$];
   bit                     held_v = 1'b0;
   logic [DSIZE*LANES-1:0] held_d = '0;
   logic [LANES-1:0]       held_k = '0;
   int                     idle = 0;

   // Record of the beats the DUT has delivered
   int                     beats = 0;
   logic [DSIZE*LANES-1:0] last_d = '0;
   logic [LANES-1:0]       last_k = '0;
   logic [DSIZE*LANES-1:0] prev_d = '0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_pack();
      held_d = '0;
      for (int i = 0; i < cur.size(); i++) held_d[i*DSIZE +: DSIZE] = cur[i];
      held_k = LANES'((1 << cur.size()) - 1);
      held_v = 1'b1;
      cur.delete();
      idle = 0;
   endtask

   // One rclk cycle: drive the inputs, check against the model, advance the model.
   task automatic step(input bit push, input logic [DSIZE-1:0] b, input bit fl,
                       input bit rdy, input bit rst);
      bit               exp_rinc;
      bit               fire;
      logic [DSIZE-1:0] pb;
      @(negedge rclk);
      if (push) fifo.push_back(b);
      rrst_n  = rst;
      flush   = fl;
      m_ready = rdy;
      rempty  = (fifo.size() == 0);
      rdata   = rempty ? '0 : fifo[0];
      #1;
      exp_rinc = rst && (fifo.size() > 0) && (!held_v || rdy);
      check_eq("rinc", rinc, exp_rinc);
      check_eq("m_valid", m_valid, held_v);
      if (held_v) begin
         check_eq("m_data", m_data, held_d);
         check_eq("m_keep", m_keep, held_k);
      end
      if (m_valid && rdy && rst) begin
         beats++;
         prev_d = last_d;
         last_d = m_data;
         last_k = m_keep;
      end
      pb = '0;
      if (exp_rinc) pb = fifo.pop_front();
      if (!rst) begin
         cur.delete();
         held_v = 1'b0;
         idle   = 0;
      end else if (held_v) begin
         if (rdy) begin
            held_v = 1'b0;
            idle   = 0;
            if (exp_rinc) cur.push_back(pb);
         end
      end else begin
         if (exp_rinc) begin
            cur.push_back(pb);
            idle = 0;
         end else if (cur.size() > 0) begin
            idle++;
         end
         fire = (cur.size() == LANES) || (fl && cur.size() > 0);
`ifdef AFIFO_PACK_TIMEOUT_EN
         if (idle == TO_CYCLES) fire = 1'b1;
`endif
         if (fire) model_pack();
      end
   endtask

   initial begin
      int b0;
      int inflight;

      // Reset
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 0, 0);
      @(posedge rclk); #1;
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_m_data", m_data, 0);
      check_eq("rst_m_keep", m_keep, 0);
      check_eq("rst_rinc", rinc, 0);

      // Full word
      step(1, 8'h11, 0, 1, 1);
      step(1, 8'h22, 0, 1, 1);
      step(1, 8'h33, 0, 1, 1);
      step(1, 8'h44, 0, 1, 1);
      step(0, '0, 0, 1, 1);
      check_eq("full_beats", beats, 1);
      check_eq("full_data", last_d, 32'h44332211);
      check_eq("full_keep", last_k, 4'hF);

      // Back-pressure
      for (int i = 0; i < 10; i++) step(i < 8, DSIZE'(i + 1), 0, 0, 1);
      check_eq("bp_no_beat", beats, 1);
      check_eq("bp_held_data", m_data, 32'h04030201);
      for (int i = 0; i < 6; i++) step(0, '0, 0, 1, 1);
      check_eq("bp_beats", beats, 3);
      check_eq("bp_first", prev_d, 32'h04030201);
      check_eq("bp_second", last_d, 32'h08070605);

      // Partial flush, then a flush with nothing captured
      step(1, 8'hAA, 0, 1, 1);
      step(1, 8'hBB, 0, 1, 1);
      step(0, '0, 1, 1, 1);
      step(0, '0, 0, 1, 1);
      check_eq("pf_data", last_d, 32'h0000BBAA);
      check_eq("pf_keep", last_k, 4'h3);
      b0 = beats;
      step(0, '0, 1, 1, 1);
      for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 1);
      check_eq("pf_empty_flush", beats, b0);

      // Flush in the same cycle a byte is popped
      step(1, 8'hCC, 1, 1, 1);
      step(0, '0, 0, 1, 1);
      check_eq("sc_data", last_d, 32'h000000CC);
      check_eq("sc_keep", last_k, 4'h1);

      // Reset in the middle of a word
      step(1, 8'h91, 0, 1, 1);
      step(1, 8'h92, 0, 1, 1);
      step(1, 8'h93, 0, 1, 1);
      step(0, '0, 0, 1, 0);
      @(posedge rclk); #1;
      check_eq("rmw_valid", m_valid, 0);
      check_eq("rmw_keep", m_keep, 0);
      step(1, 8'hA1, 0, 1, 1);
      step(1, 8'hA2, 0, 1, 1);
      step(1, 8'hA3, 0, 1, 1);
      step(1, 8'hA4, 0, 1, 1);
      step(0, '0, 0, 1, 1);
      check_eq("rmw_data", last_d, 32'hA4A3A2A1);
      check_eq("rmw_keep_full", last_k, 4'hF);

      // Idle behaviour after a single byte
      b0 = beats;
      step(1, 8'h5A, 0, 1, 1);
      for (int i = 0; i < 100; i++) step(0, '0, 0, 1, 1);
`ifdef AFIFO_PACK_TIMEOUT_EN
      check_eq("to_beats", beats, b0 + 1);
      check_eq("to_keep", last_k, 4'h1);
      check_eq("to_data", last_d, 32'h0000005A);
`else
      check_eq("noto_beats", beats, b0);
      step(0, '0, 1, 1, 1);
      step(0, '0, 0, 1, 1);
      check_eq("noto_flush_data", last_d, 32'h0000005A);
`endif

      // Randomized traffic; the model checks every cycle
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 2) != 0, DSIZE'($urandom),
              $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 299) != 0);
      end

      // Drain whatever is left
      inflight = fifo.size() + cur.size();
      for (int i = 0; i < 40 + inflight * 2; i++) step(0, '0, (i % 8) == 7, 1, 1);
      check_eq("drain_fifo_empty", fifo.size(), 0);
      check_eq("drain_no_valid", m_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
